// File: rtl/reg_share_arbiter.sv
// ============================================================================
// reg_share_arbiter
//
// Round-robin arbiter that shares one DATA_W-bit holding register among
// NUM_REQ requesters. The winner owns the register for up to MAX_HOLD
// consecutive captures. Priority then rotates to the requester after it.
// Every release is followed by one idle (bubble) cycle before the next grant.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   req        in   [NUM_REQ]          request per requester
//   req_data   in   [NUM_REQ*DATA_W]   packed data, requester i at [i*DATA_W +: DATA_W]
//   gnt        out  [NUM_REQ]          registered one-hot grant, zero when idle
//   owner_id   out  [clog2(NUM_REQ)]   index of current/last owner
//   data_out   out  [DATA_W]           shared register contents
//   data_valid out                     high in the cycle after a capture edge
//   busy       out                     high while a requester owns the register
// ============================================================================
module reg_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_W-1:0]       req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [$clog2(NUM_REQ)-1:0]      owner_id,
    output logic [DATA_W-1:0]               data_out,
    output logic                            data_valid,
    output logic                            busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]  HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [IDW-1:0]      ptr_q, ptr_d;

    logic                win_found;
    logic [IDW-1:0]      win_idx;
    logic [IDW-1:0]      cand_idx;

    // State register: reset is synchronous and overrides any capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    // Round-robin search starting at ptr; the first active request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state logic. A release never captures, so data_out holds through
    // the bubble cycle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        data_d  = data_q;
        valid_d = 1'b0;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    data_d  = req_data[win_idx*DATA_W +: DATA_W];
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    hold_d  = HW'(1);
                    valid_d = 1'b1;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (req[owner_q] && (hold_q < HOLD_LIMIT)) begin
                    data_d  = req_data[owner_q*DATA_W +: DATA_W];
                    hold_d  = hold_q + HW'(1);
                    valid_d = 1'b1;
                end else begin
                    gnt_d   = '0;
                    hold_d  = '0;
                    ptr_d   = (owner_q == LAST_ID) ? '0 : owner_q + IDW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from registers, so req has no combinational path to gnt.
    always_comb begin
        gnt        = gnt_q;
        owner_id   = owner_q;
        data_out   = data_q;
        data_valid = valid_q;
        busy       = (state_q == OWNED);
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// ============================================================================
// tb_reg_share_arbiter
//
// Directed testbench for reg_share_arbiter (NUM_REQ=4, DATA_W=8, MAX_HOLD=4).
// Each applied vector carries its hand-computed expected outputs after the
// following clock edge. A separate monitor pops and compares them.
// ============================================================================
module tb_reg_share_arbiter;

    typedef struct {
        string       label;
        logic [3:0]  gnt;
        logic [1:0]  own;
        logic [7:0]  data;
        logic        valid;
        logic        busy;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [1:0]  owner_id;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        busy;

    exp_t expQ[$];
    int   vecCount  = 0;
    int   missCount = 0;

    reg_share_arbiter #(
        .NUM_REQ  (4),
        .DATA_W   (8),
        .MAX_HOLD (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .owner_id   (owner_id),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one vector on the falling edge and queue what the DUT should
    // show after the next rising edge.
    task automatic applyStimulus(input string label, input logic r, input logic [3:0] rq,
                                 input logic [7:0] d3, input logic [7:0] d2,
                                 input logic [7:0] d1, input logic [7:0] d0,
                                 input logic [3:0] eGnt, input logic [1:0] eOwn,
                                 input logic [7:0] eData, input logic eValid,
                                 input logic eBusy);
        exp_t e;
        @(negedge clk);
        rst      = r;
        req      = rq;
        req_data = {d3, d2, d1, d0};
        e.label  = label;
        e.gnt    = eGnt;
        e.own    = eOwn;
        e.data   = eData;
        e.valid  = eValid;
        e.busy   = eBusy;
        expQ.push_back(e);
    endtask

    // Compare one expected entry against the live DUT outputs.
    task automatic checkOutput(input exp_t e);
        vecCount++;
        if (gnt !== e.gnt || owner_id !== e.own || data_out !== e.data ||
            data_valid !== e.valid || busy !== e.busy) begin
            missCount++;
            $display("[TB] FAIL %s: got gnt=%b own=%0d data=%h valid=%b busy=%b, expected gnt=%b own=%0d data=%h valid=%b busy=%b",
                     e.label, gnt, owner_id, data_out, data_valid, busy,
                     e.gnt, e.own, e.data, e.valid, e.busy);
        end
    endtask

    // Monitor: one expected entry is due 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Directed vectors
    initial begin
        rst      = 1'b0;
        req      = 4'b0000;
        req_data = '0;

        // Reset held with all requests active, then first grant to requester 0
        applyStimulus("reset_1",    0, 4'b1111, 8'h40, 8'h30, 8'h20, 8'h10, 4'b0000, 0, 8'h00, 0, 0);
        applyStimulus("reset_2",    0, 4'b1111, 8'h40, 8'h30, 8'h20, 8'h10, 4'b0000, 0, 8'h00, 0, 0);
        applyStimulus("first_gnt",  1, 4'b1111, 8'h40, 8'h30, 8'h20, 8'h10, 4'b0001, 0, 8'h10, 1, 1);
        applyStimulus("drop_rel",   1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h10, 0, 0);
        applyStimulus("idle",       1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h10, 0, 0);

        // Single requester runs to the hold limit, releases, is re-granted
        applyStimulus("hold_1",     1, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hA5, 4'b0001, 0, 8'hA5, 1, 1);
        applyStimulus("hold_2",     1, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hA5, 4'b0001, 0, 8'hA5, 1, 1);
        applyStimulus("hold_3",     1, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hA5, 4'b0001, 0, 8'hA5, 1, 1);
        applyStimulus("hold_4",     1, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hA5, 4'b0001, 0, 8'hA5, 1, 1);
        applyStimulus("hold_rel",   1, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hA5, 4'b0000, 0, 8'hA5, 0, 0);
        applyStimulus("hold_regnt", 1, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hA5, 4'b0001, 0, 8'hA5, 1, 1);
        applyStimulus("hold_drop",  1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'hA5, 0, 0);

        // Wrap-around: requester 3 bursts to the limit, ptr wraps to 0
        applyStimulus("wrap_gnt3",  1, 4'b1000, 8'hC3, 8'h00, 8'h00, 8'h00, 4'b1000, 3, 8'hC3, 1, 1);
        applyStimulus("wrap_c2",    1, 4'b1001, 8'hC4, 8'h00, 8'h00, 8'h55, 4'b1000, 3, 8'hC4, 1, 1);
        applyStimulus("wrap_c3",    1, 4'b1001, 8'hC5, 8'h00, 8'h00, 8'h55, 4'b1000, 3, 8'hC5, 1, 1);
        applyStimulus("wrap_c4",    1, 4'b1001, 8'hC6, 8'h00, 8'h00, 8'h55, 4'b1000, 3, 8'hC6, 1, 1);
        applyStimulus("wrap_rel",   1, 4'b1001, 8'hC7, 8'h00, 8'h00, 8'h55, 4'b0000, 3, 8'hC6, 0, 0);
        applyStimulus("wrap_gnt0",  1, 4'b1001, 8'hC7, 8'h00, 8'h00, 8'h55, 4'b0001, 0, 8'h55, 1, 1);
        applyStimulus("wrap_drop",  1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h55, 0, 0);

        // Mid-burst reset, then re-grant with a fresh hold count
        applyStimulus("mid_gnt1",   1, 4'b0010, 8'h00, 8'h00, 8'h7D, 8'h00, 4'b0010, 1, 8'h7D, 1, 1);
        applyStimulus("mid_c2",     1, 4'b0010, 8'h00, 8'h00, 8'h7E, 8'h00, 4'b0010, 1, 8'h7E, 1, 1);
        applyStimulus("mid_reset",  0, 4'b0010, 8'h00, 8'h00, 8'h7F, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
        applyStimulus("mid_regnt",  1, 4'b0010, 8'h00, 8'h00, 8'h81, 8'h00, 4'b0010, 1, 8'h81, 1, 1);
        applyStimulus("mid_c2b",    1, 4'b0010, 8'h00, 8'h00, 8'h82, 8'h00, 4'b0010, 1, 8'h82, 1, 1);
        applyStimulus("mid_c3b",    1, 4'b0010, 8'h00, 8'h00, 8'h83, 8'h00, 4'b0010, 1, 8'h83, 1, 1);
        applyStimulus("mid_c4b",    1, 4'b0010, 8'h00, 8'h00, 8'h84, 8'h00, 4'b0010, 1, 8'h84, 1, 1);
        applyStimulus("mid_rel",    1, 4'b0010, 8'h00, 8'h00, 8'h85, 8'h00, 4'b0000, 1, 8'h84, 0, 0);

        // Reset to bring ptr back to 0, then rotation from 0 to 2
        applyStimulus("rot_reset",  0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
        applyStimulus("rot_gnt0",   1, 4'b0101, 8'h00, 8'h3C, 8'h00, 8'h11, 4'b0001, 0, 8'h11, 1, 1);
        applyStimulus("rot_c2",     1, 4'b0101, 8'h00, 8'h3C, 8'h00, 8'h22, 4'b0001, 0, 8'h22, 1, 1);
        applyStimulus("rot_rel",    1, 4'b0100, 8'h00, 8'h3C, 8'h00, 8'h00, 4'b0000, 0, 8'h22, 0, 0);
        applyStimulus("rot_gnt2",   1, 4'b0100, 8'h00, 8'h3C, 8'h00, 8'h00, 4'b0100, 2, 8'h3C, 1, 1);

        // Non-owner request ignored mid-burst, then one bubble and grant
        applyStimulus("nonown_c2",  1, 4'b0101, 8'h00, 8'h3D, 8'h00, 8'h99, 4'b0100, 2, 8'h3D, 1, 1);
        applyStimulus("nonown_c3",  1, 4'b0101, 8'h00, 8'h3E, 8'h00, 8'h99, 4'b0100, 2, 8'h3E, 1, 1);
        applyStimulus("nonown_rel", 1, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h99, 4'b0000, 2, 8'h3E, 0, 0);
        applyStimulus("nonown_gnt", 1, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h99, 4'b0001, 0, 8'h99, 1, 1);
        applyStimulus("end_rel",    1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h99, 0, 0);
        applyStimulus("end_idle",   1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h99, 0, 0);

        // Give the monitor a bounded window to drain the queue
        repeat (2) @(posedge clk);
        #3;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter sharing one DATA_W-bit holding register among NUM_REQ requesters.
- Grants one requester ownership for a bounded burst of captures, then rotates priority.
- Sits in front of the shared data register. Downstream sees one registered data word plus an owner tag.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- DATA_W, 8: width of each requester's data and of data_out.
- MAX_HOLD, 4: maximum consecutive captures per grant; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (low = reset, sampled on the clk rising edge).
- req  input  NUM_REQ  request per requester; held high while it has data.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i uses bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- owner_id  output  clog2(NUM_REQ)  binary index of the current owner; holds its last value when idle.
- data_out  output  DATA_W  shared register contents.
- data_valid  output  1  high in each cycle following an edge that captured data.
- busy  output  1  high while the FSM is in OWNED.

Behaviour:
- Reset:
  - Applies when rst = 0 at a clk edge.
  - Clears gnt, owner_id, data_out, data_valid, busy, hold_cnt and the priority pointer ptr.
  - Next state is IDLE.
  - Reset overrides everything, including an active burst; no capture occurs on a reset edge.
- State IDLE:
  - If req == 0, stay in IDLE; all outputs except data_out and owner_id stay 0/low.
  - Otherwise the winner w is the first i with req[i] = 1, searching ptr, ptr+1, … mod NUM_REQ.
  - At the edge: data_out <= req_data[w]; gnt <= onehot(w); owner_id <= w; hold_cnt <= 1; data_valid <= 1; busy <= 1; state -> OWNED.
- State OWNED (owner o):
  - Continue when req[o] = 1 and hold_cnt < MAX_HOLD. At the edge: data_out <= req_data[o]; hold_cnt++; gnt, owner_id and busy unchanged; data_valid <= 1.
  - Release when req[o] = 0 or hold_cnt == MAX_HOLD. At the edge: no capture; gnt <= 0; data_valid <= 0; busy <= 0; ptr <= (o+1) mod NUM_REQ; state -> IDLE.
  - Requests from non-owners are ignored during OWNED.
- Timing:
  - Exactly one bubble cycle (IDLE) between any release and the next grant.
  - No combinational path from req to gnt.
  - data_out changes only on capture edges and holds otherwise; it is never cleared except by reset.
- MAX_HOLD = 1: every grant captures once, then releases on the next edge.
- Fairness: a requester held high continuously waits at most NUM_REQ-1 other bursts.
- hold_cnt is clog2(MAX_HOLD+1) bits wide and never exceeds MAX_HOLD.
- Capture timing: data is sampled at the edge itself. req_data[i] must be valid whenever req[i] is high, including in the cycle before the grant.

Test Plan:
1. Reset: rst = 0 for 2 cycles with req = 4'b1111 -> gnt = 0, data_out = 8'h00, data_valid = 0, busy = 0. Release rst -> first grant to requester 0 on the next edge.
2. Single requester at the hold limit: req = 4'b0001, req_data[0] = 8'hA5 held.
   - Edges 1–4 capture: gnt = 0001, data_valid = 1, hold_cnt reaches 4.
   - Edge 5 releases: gnt = 0, data_out remains 8'hA5.
   - Edge 6 re-grants requester 0.
3. Rotation: req = 4'b0101 from IDLE with ptr = 0.
   - Requester 0 granted; it drops req after 2 captures (data 8'h11, 8'h22).
   - Release sets ptr = 1; after the bubble, requester 2 is granted (owner_id = 2, data_out = req_data[2] = 8'h3C).
4. Wrap-around: requester 3 owns and releases with req = 4'b1001 -> ptr wraps to 0; requester 0 is granted next, not 3.
5. Mid-burst reset: requester 1 owning with hold_cnt = 2, data_out = 8'h7E; rst = 0 for one edge -> all outputs clear, data_out = 8'h00. Release rst with req = 4'b0010 -> requester 1 is re-granted with hold_cnt = 1.
6. Non-owner ignored: requester 2 owns; req[0] rises mid-burst -> gnt stays 0100 until requester 2 releases. Then requester 0 is granted after exactly one bubble cycle.
